// File: rtl/uart_song_tx.sv
// ---------------------------------------------------------------------------
// uart_song_tx
//
// Transmit side of the Bluetooth UART link. On request it walks the song
// buffer from address 0 to DEPTH-1 and sends each byte as an 8N1 frame on
// txd, so a phone can read the stored tune back.
//
// Byte timeline (BIT_CYC = CLK_HZ/BAUD clocks per bit):
//   FETCH (1 clk) -> LOAD (1 clk) -> START (BIT_CYC) -> DATA (8*BIT_CYC)
//   -> STOP (BIT_CYC) -> next FETCH, or IDLE when the dump ends.
// The period per byte is therefore 10*BIT_CYC + 2 clocks.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   start      in   level; 1 while IDLE begins a dump
//   abort      in   level; ends the dump after the frame in flight
//   rd_addr    out  song buffer read address (also the byte index)
//   rd_data    in   song buffer data, valid one clock after rd_addr
//   txd        out  serial line, idles high
//   busy       out  1 while a dump is in progress
//   byte_sent  out  1-clk pulse at the end of each stop bit
//   done       out  1-clk pulse when a dump ends (completed or aborted)
//
// Every output comes straight from a flop. txd is computed from the current
// state and registered, so the line lags the state register by one clock;
// the 2-clock FETCH/LOAD gap plus that lag puts the start bit on the line
// three edges after start is sampled.
// ---------------------------------------------------------------------------
module uart_song_tx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              txd,
  output logic              busy,
  output logic              byte_sent,
  output logic              done
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;       // byte index, drives rd_addr
  logic [BAUD_W-1:0]   baud_q, baud_d;     // clocks within the current bit
  logic [2:0]          bit_q, bit_d;       // data bit number 0..7
  logic [7:0]          shift_q, shift_d;   // byte being serialised, LSB out
  logic                abort_q, abort_d;   // sticky abort request
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                byte_sent_q, byte_sent_d;
  logic                done_q, done_d;

  logic                bit_tick;
  logic                last_byte;

  assign bit_tick  = (baud_q == BAUD_LAST);
  // An abort arriving on the very last stop-bit clock still ends the dump.
  assign last_byte = abort_q || abort || (idx_q == IDX_LAST);

  // -------------------------------------------------------------------------
  // State register and output flops
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      abort_q     <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      byte_sent_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      abort_q     <= abort_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      byte_sent_q <= byte_sent_d;
      done_q      <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    idx_d       = idx_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    abort_d     = abort_q;
    byte_sent_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end

      // rd_addr already holds idx; the RAM registers it on this edge.
      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d = rd_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end

      S_START: begin
        if (bit_tick) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          baud_d      = '0;
          byte_sent_d = 1'b1;
          if (last_byte) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky abort: latched anywhere outside IDLE, honoured at the stop bit.
    if (state_q != S_IDLE && abort) begin
      abort_d = 1'b1;
    end
  end

  // Line level follows the current state; registered one clock later.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // busy follows the next state so it falls on the same edge done rises.
  assign busy_d = (state_d != S_IDLE);

  assign rd_addr   = idx_q;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign byte_sent = byte_sent_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_song_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_song_tx
//
// Bench for uart_song_tx with CLK_HZ=160, BAUD=10 (16 clocks per bit, 162
// clocks per byte). A registered song RAM model feeds rd_data; a line
// decoder turns txd back into bytes and compares them against a queue of
// expected bytes pushed when each dump is started. Edge numbers are counted
// from the edge on which start is sampled (t0).
// ---------------------------------------------------------------------------
module tb_uart_song_tx;

  localparam int unsigned CLK_HZ = 160;
  localparam int unsigned BAUD   = 10;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int          PERIOD = 162;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              txd;
  logic              busy;
  logic              byte_sent;
  logic              done;

  logic [7:0] ram [DEPTH];

  int cyc        = 0;
  int rst_cnt    = 0;
  int t0         = 0;
  int pass_cnt   = 0;
  int check_cnt  = 0;
  int bs_count   = 0;
  int done_count = 0;
  int done_edge  = 0;
  int rx_count   = 0;

  logic [7:0] exp_q [$];

  typedef struct {
    int          rel;
    logic        start_in;
    logic        abort_in;
    logic        txd_e;
    logic        busy_e;
    logic        bs_e;
    logic        done_e;
    logic [5:0]  addr_e;
  } vec_t;

  vec_t vecs [19];

  uart_song_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .txd      (txd),
    .busy     (busy),
    .byte_sent(byte_sent),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;
  always @(posedge clk) rd_data <= ram[rd_addr];

  // Pulse counters, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (byte_sent === 1'b1) bs_count++;
    if (done === 1'b1) begin
      done_count++;
      done_edge = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line decoder: centre-samples each bit of every frame. Frames cut short by
  // a reset are discarded.
  initial begin : uart_mon
    logic [7:0] b;
    logic       ok;
    int         rst_base;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        b        = '0;
        ok       = 1'b1;
        rst_base = rst_cnt;
        for (int k = 1; k <= 152; k++) begin
          @(negedge clk);
          if (k == 8 && txd !== 1'b0) ok = 1'b0;
          if (k >= 24 && k <= 136 && ((k - 8) % 16) == 0) b[3'((k - 24) / 16)] = txd;
          if (k == 152 && txd !== 1'b1) ok = 1'b0;
        end
        if (rst_cnt == rst_base) begin
          rx_count++;
          check("rx_framing", ok, 1);
          check("rx_frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_rel(input int r);
    while (cyc < t0 + r) @(negedge clk);
  endtask

  task automatic start_dump();
    @(negedge clk);
    start = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, input string name);
    while (done_count == base && cyc < t0 + limit) @(negedge clk);
    check({name, "_done_seen"}, done_count - base, 1);
  endtask

  task automatic run_full(input logic extra_starts, input string name);
    int bsb, db, rxb;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i] = 8'(i);
      exp_q.push_back(8'(i));
    end
    bsb = bs_count;
    db  = done_count;
    rxb = rx_count;
    start_dump();
    if (extra_starts) begin
      wait_rel(3 * PERIOD);  // byte 3 FETCH/LOAD/START
      start = 1'b1;
      wait_rel(3 * PERIOD + 3);
      start = 1'b0;
      wait_rel(5000);
      start = 1'b1;
      wait_rel(5001);
      start = 1'b0;
    end
    wait_rel(64 * PERIOD - 1);
    check({name, "_busy_before_done"}, busy, 1);
    check({name, "_done_early"}, done, 0);
    check({name, "_last_addr"}, rd_addr, 63);
    wait_done(db, 64 * PERIOD + 200, name);
    check({name, "_done_edge"}, done_edge - t0, 64 * PERIOD);
    check({name, "_busy_after_done"}, busy, 0);
    check({name, "_byte_sent_count"}, bs_count - bsb, 64);
    check({name, "_rx_count"}, rx_count - rxb, 64);
    check({name, "_rx_all_seen"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int bsb, db, rxb;

    // Scenario 2 table: {rel edge, start, abort, txd, busy, byte_sent, done, rd_addr}
    vecs[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{2,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[2]  = '{3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[3]  = '{18,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{19,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[5]  = '{34,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[6]  = '{35,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[7]  = '{50,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[8]  = '{51,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[9]  = '{99,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[10] = '{110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[11] = '{130, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[12] = '{131, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[13] = '{146, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[14] = '{147, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[15] = '{161, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[16] = '{162, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0};
    vecs[17] = '{163, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[18] = '{300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0};

    for (int i = 0; i < int'(DEPTH); i++) ram[i] = 8'(i);

    // 1: reset
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byte_sent", byte_sent, 0);
    check("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2: single frame of 0x55, ignored start mid-frame, abort ends after byte 0
    ram[0] = 8'h55;
    exp_q.push_back(8'h55);
    rxb = rx_count;
    start_dump();
    for (int i = 0; i < 19; i++) begin
      wait_rel(vecs[i].rel);
      check($sformatf("v%0d_txd", i), txd, vecs[i].txd_e);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy_e);
      check($sformatf("v%0d_byte_sent", i), byte_sent, vecs[i].bs_e);
      check($sformatf("v%0d_done", i), done, vecs[i].done_e);
      check($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].addr_e);
      start = vecs[i].start_in;
      abort = vecs[i].abort_in;
    end
    check("s2_rx_count", rx_count - rxb, 1);
    check("s2_rx_all_seen", exp_q.size(), 0);

    // 3: full dump
    run_full(1'b0, "s3");

    // 5: extra start pulses during a dump change nothing
    repeat (5) @(negedge clk);
    run_full(1'b1, "s5");

    // start+abort held at done: new dump on the next edge, ends after byte 0
    exp_q.push_back(ram[0]);
    db    = done_count;
    start = 1'b1;
    abort = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_rd_addr", rd_addr, 0);
    wait_done(db, PERIOD + 100, "restart");
    abort = 1'b0;
    check("restart_done_edge", done_edge - t0, PERIOD);
    check("restart_busy_after", busy, 0);

    // 4: abort in IDLE is ignored; abort during byte 5 DATA ends after byte 5
    repeat (200) @(negedge clk);
    check("idle_rx_drained", exp_q.size(), 0);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(ram[i]);
    bsb = bs_count;
    db  = done_count;
    rxb = rx_count;
    start_dump();
    wait_rel(5 * PERIOD + 90);
    abort = 1'b1;
    wait_rel(5 * PERIOD + 91);
    abort = 1'b0;
    wait_done(db, 6 * PERIOD + 200, "s4");
    check("s4_done_edge", done_edge - t0, 6 * PERIOD);
    check("s4_rd_addr", rd_addr, 5);
    check("s4_busy", busy, 0);
    repeat (400) @(negedge clk);
    check("s4_byte_sent_count", bs_count - bsb, 6);
    check("s4_done_count", done_count - db, 1);
    check("s4_rx_count", rx_count - rxb, 6);
    check("s4_rx_all_seen", exp_q.size(), 0);
    check("s4_rd_addr_hold", rd_addr, 5);

    // 6: reset during DATA of byte 2, then a fresh dump starts at RAM[0]
    exp_q.push_back(ram[0]);
    exp_q.push_back(ram[1]);
    rxb = rx_count;
    start_dump();
    wait_rel(400);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_txd", txd, 1);
    check("s6_busy", busy, 0);
    check("s6_rd_addr", rd_addr, 0);
    check("s6_byte_sent", byte_sent, 0);
    check("s6_done", done, 0);
    repeat (300) @(negedge clk);
    check("s6_rx_count", rx_count - rxb, 2);
    check("s6_rx_all_seen", exp_q.size(), 0);
    check("s6_idle_txd", txd, 1);
    ram[0] = 8'hA7;
    exp_q.push_back(8'hA7);
    db    = done_count;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    t0    = cyc;
    start = 1'b0;
    wait_done(db, PERIOD + 100, "s6_resend");
    abort = 1'b0;
    check("s6_resend_done_edge", done_edge - t0, PERIOD);
    repeat (20) @(negedge clk);
    check("s6_resend_rx", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
